// File: rtl/nco_sweep_controller.sv
// NCO sweep controller: steps the phase-accumulator tuning word from a
// start word to a stop word, holding each word for a programmable dwell.
//
// Ports:
//   clk_in      system clock, rising edge
//   rst         synchronous active-high reset
//   start       begin a sweep (sampled only when idle)
//   abort       stop the active sweep, ftw_out holds
//   ftw_start   first tuning word
//   ftw_stop    final tuning word
//   ftw_step    unsigned step magnitude
//   dwell       cycles per word (0 behaves as 1)
//   ftw_out     tuning word to the phase accumulator
//   ftw_update  one-cycle strobe on each new ftw_out
//   busy        sweep active
//   done        one-cycle pulse on normal completion
//
// Build option: define NCO_SWEEP_BIDIR_EN for a continuous triangle sweep
// (direction reverses at each end, done never pulses).

module nco_sweep_controller #(
    parameter int FTW_WIDTH   = 24,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [FTW_WIDTH-1:0]   ftw_start,
    input  logic [FTW_WIDTH-1:0]   ftw_stop,
    input  logic [FTW_WIDTH-1:0]   ftw_step,
    input  logic [DWELL_WIDTH-1:0] dwell,
    output logic [FTW_WIDTH-1:0]   ftw_out,
    output logic                   ftw_update,
    output logic                   busy,
    output logic                   done
);

`ifdef NCO_SWEEP_BIDIR_EN
    localparam bit BIDIR_EN = 1'b1;
`else
    localparam bit BIDIR_EN = 1'b0;
`endif

    localparam logic [DWELL_WIDTH-1:0] DW_ONE = DWELL_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DWELL,
        FINISH
    } state_t;

    state_t                 state_q, state_d;
    logic [FTW_WIDTH-1:0]   cfg_start_q, cfg_start_d;
    logic [FTW_WIDTH-1:0]   cfg_stop_q, cfg_stop_d;
    logic [FTW_WIDTH-1:0]   cfg_step_q, cfg_step_d;
    logic [DWELL_WIDTH-1:0] cfg_dwell_q, cfg_dwell_d;
    logic [DWELL_WIDTH-1:0] timer_q, timer_d;
    logic                   dir_up_q, dir_up_d;
    logic                   last_q, last_d;
    logic [FTW_WIDTH-1:0]   ftw_d;
    logic                   upd_d, busy_d, done_d;

    logic [FTW_WIDTH:0]     sum, diff;
    logic                   step_up;
    logic [FTW_WIDTH-1:0]   step_stop;
    logic [FTW_WIDTH-1:0]   next_word;
    logic                   next_is_stop;

    // Next sweep point. At a triangle turnaround the step is taken in the
    // reversed direction toward the old start, so the end word is not repeated.
    always_comb begin
        step_up   = dir_up_q;
        step_stop = cfg_stop_q;
        if (BIDIR_EN && last_q) begin
            step_up   = ~dir_up_q;
            step_stop = cfg_start_q;
        end
        sum  = {1'b0, ftw_out} + {1'b0, cfg_step_q};
        diff = {1'b0, ftw_out} - {1'b0, cfg_step_q};
        if (step_up) begin
            if (sum[FTW_WIDTH] || (sum[FTW_WIDTH-1:0] >= step_stop))
                next_word = step_stop;
            else
                next_word = sum[FTW_WIDTH-1:0];
        end else begin
            if (diff[FTW_WIDTH] || (diff[FTW_WIDTH-1:0] <= step_stop))
                next_word = step_stop;
            else
                next_word = diff[FTW_WIDTH-1:0];
        end
        next_is_stop = (next_word == step_stop);
    end

    always_comb begin
        state_d     = state_q;
        cfg_start_d = cfg_start_q;
        cfg_stop_d  = cfg_stop_q;
        cfg_step_d  = cfg_step_q;
        cfg_dwell_d = cfg_dwell_q;
        timer_d     = timer_q;
        dir_up_d    = dir_up_q;
        last_d      = last_q;
        ftw_d       = ftw_out;
        upd_d       = 1'b0;
        busy_d      = busy;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    cfg_start_d = ftw_start;
                    cfg_stop_d  = ftw_stop;
                    cfg_step_d  = ftw_step;
                    cfg_dwell_d = (dwell == '0) ? DW_ONE : dwell;
                    dir_up_d    = (ftw_stop >= ftw_start);
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                ftw_d   = cfg_start_q;
                upd_d   = 1'b1;
                busy_d  = 1'b1;
                timer_d = cfg_dwell_q - DW_ONE;
                last_d  = (cfg_step_q == '0) ||
                          (cfg_start_q == cfg_stop_q);
                state_d = DWELL;
            end
            DWELL: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - DW_ONE;
                end else if (last_q && !BIDIR_EN) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = FINISH;
                end else begin
                    ftw_d   = next_word;
                    upd_d   = 1'b1;
                    timer_d = cfg_dwell_q - DW_ONE;
                    last_d  = next_is_stop;
                    if (last_q) begin
                        cfg_start_d = cfg_stop_q;
                        cfg_stop_d  = cfg_start_q;
                        dir_up_d    = ~dir_up_q;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            ftw_d   = ftw_out;
            upd_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q     <= IDLE;
            cfg_start_q <= '0;
            cfg_stop_q  <= '0;
            cfg_step_q  <= '0;
            cfg_dwell_q <= '0;
            timer_q     <= '0;
            dir_up_q    <= 1'b0;
            last_q      <= 1'b0;
            ftw_out     <= '0;
            ftw_update  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_start_q <= cfg_start_d;
            cfg_stop_q  <= cfg_stop_d;
            cfg_step_q  <= cfg_step_d;
            cfg_dwell_q <= cfg_dwell_d;
            timer_q     <= timer_d;
            dir_up_q    <= dir_up_d;
            last_q      <= last_d;
            ftw_out     <= ftw_d;
            ftw_update  <= upd_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

endmodule

// File: tb/tb_nco_sweep_controller.sv
// Testbench for nco_sweep_controller: directed and random sweeps checked
// every cycle against a word-list model of the sweep.

module tb_nco_sweep_controller;

`ifdef NCO_SWEEP_BIDIR_EN
    localparam bit BIDIR = 1'b1;
`else
    localparam bit BIDIR = 1'b0;
`endif

    logic        clk_in;
    logic        rst;
    logic        start;
    logic        abort;
    logic [23:0] ftw_start;
    logic [23:0] ftw_stop;
    logic [23:0] ftw_step;
    logic [15:0] dwell;
    logic [23:0] ftw_out;
    logic        ftw_update;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    nco_sweep_controller #(
        .FTW_WIDTH(24),
        .DWELL_WIDTH(16)
    ) dut (
        .clk_in(clk_in),
        .rst(rst),
        .start(start),
        .abort(abort),
        .ftw_start(ftw_start),
        .ftw_stop(ftw_stop),
        .ftw_step(ftw_step),
        .dwell(dwell),
        .ftw_out(ftw_out),
        .ftw_update(ftw_update),
        .busy(busy),
        .done(done)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint leg[$];
    longint words[$];
    bit     m_valid = 1'b0;
    bit     m_act   = 1'b0;
    longint m_cyc   = 0;
    longint m_t0    = 0;
    longint m_d     = 1;
    longint m_k     = 1;
    logic [23:0] e_ftw;
    logic        e_upd, e_busy, e_done;

    // Word list of one linear leg from s toward e, clamped at e.
    task automatic make_leg(input longint s, input longint e,
                            input longint st);
        longint w;
        leg.delete();
        w = s;
        leg.push_back(w);
        if (st != 0) begin
            while (w != e && leg.size() < 5000) begin
                if (e >= s) w = (w + st >= e) ? e : w + st;
                else        w = (w - st <= e) ? e : w - st;
                leg.push_back(w);
            end
        end
    endtask

    task automatic build_words(input longint s, input longint e,
                               input longint st);
        longint a, b, t;
        make_leg(s, e, st);
        words = leg;
        m_k = words.size();
        if (BIDIR) begin
            a = s;
            b = e;
            while (words.size() < 400) begin
                make_leg(b, a, st);
                if (leg.size() < 2) break;
                for (int i = 1; i < leg.size(); i++)
                    words.push_back(leg[i]);
                t = a;
                a = b;
                b = t;
            end
        end
    endtask

    task automatic model_edge();
        longint rel;
        longint idx;
        e_upd  = 1'b0;
        e_done = 1'b0;
        if (rst) begin
            m_act  = 1'b0;
            e_ftw  = '0;
            e_busy = 1'b0;
        end else if (m_act) begin
            rel = m_cyc - m_t0;
            if (abort && (BIDIR || rel <= m_k * m_d)) begin
                m_act  = 1'b0;
                e_busy = 1'b0;
            end else if (BIDIR || rel < m_k * m_d) begin
                idx    = rel / m_d;
                e_busy = 1'b1;
                if (rel % m_d == 0 && idx < words.size()) begin
                    e_upd = 1'b1;
                    e_ftw = 24'(words[idx]);
                end
            end else if (rel == m_k * m_d) begin
                e_done = 1'b1;
                e_busy = 1'b0;
            end else begin
                m_act = 1'b0;
            end
        end else if (start && !abort) begin
            m_act = 1'b1;
            m_t0  = m_cyc + 1;
            m_d   = (dwell == 0) ? 1 : longint'(dwell);
            build_words(ftw_start, ftw_stop, ftw_step);
        end
        m_cyc++;
        m_valid = 1'b1;
    endtask

    initial forever begin
        @(posedge clk_in);
        model_edge();
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk_in);
        if (m_valid) begin
            chk("ftw_out", ftw_out, e_ftw);
            chk("ftw_update", ftw_update, e_upd);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic set_cfg(input logic [23:0] s, input logic [23:0] e,
                           input logic [23:0] st, input logic [15:0] d);
        ftw_start = s;
        ftw_stop  = e;
        ftw_step  = st;
        dwell     = d;
    endtask

    task automatic rand_cfg();
        logic [23:0] s, e, st;
        int unsigned r;
        int m;
        s = 24'($urandom);
        e = 24'($urandom);
        m = $urandom_range(0, 9);
        if (m == 1) e = s + 24'($urandom_range(0, 40));
        if (m == 0 && !BIDIR) e = s;
        r  = (e >= s) ? 32'(e - s) : 32'(s - e);
        st = 24'(r / $urandom_range(1, 8)) + 24'($urandom_range(0, 3));
        if (m == 2 && !BIDIR) st = '0;
        if (m == 3) begin
            s  = 24'hFFFF00 | 24'($urandom_range(0, 255));
            e  = 24'hFFFFF0 | 24'($urandom_range(0, 15));
            st = 24'($urandom_range(1, 256));
        end
        if (m == 4) begin
            s  = 24'($urandom_range(0, 255));
            e  = 24'($urandom_range(0, 15));
            st = 24'($urandom_range(1, 256));
        end
        if (BIDIR) begin
            if (st == '0) st = 24'd1;
            if (e == s) e = s ^ 24'd1;
        end
        set_cfg(s, e, st, 16'($urandom_range(0, 4)));
    endtask

    longint pin_up[4]   = '{100, 110, 120, 130};
    longint pin_dn[4]   = '{50, 30, 10, 5};
    longint pin_ov[2]   = '{24'hFFFFF0, 24'hFFFFFF};
    logic [23:0] tri_seq[7] = '{0, 10, 20, 10, 0, 10, 20};

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        set_cfg(0, 0, 0, 0);

        make_leg(100, 130, 10);
        chk("pin_up_len", leg.size(), 4);
        foreach (pin_up[i]) chk("pin_up_word", leg[i], pin_up[i]);
        make_leg(50, 5, 20);
        chk("pin_dn_len", leg.size(), 4);
        foreach (pin_dn[i]) chk("pin_dn_word", leg[i], pin_dn[i]);
        make_leg(24'hFFFFF0, 24'hFFFFFF, 24'h20);
        chk("pin_ov_len", leg.size(), 2);
        foreach (pin_ov[i]) chk("pin_ov_word", leg[i], pin_ov[i]);

        tick();
        tick();
        chk("rst_ftw", ftw_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_upd", ftw_update, 0);
        rst = 1'b0;
        tick();

`ifndef NCO_SWEEP_BIDIR_EN
        set_cfg(100, 130, 10, 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("up_first_ftw", ftw_out, 100);
        chk("up_first_upd", ftw_update, 1);
        chk("up_first_busy", busy, 1);
        repeat (2) tick();
        chk("up_hold_upd", ftw_update, 0);
        tick();
        chk("up_second_ftw", ftw_out, 110);
        chk("up_second_upd", ftw_update, 1);
        repeat (6) tick();
        chk("up_last_ftw", ftw_out, 130);
        repeat (3) tick();
        chk("up_done", done, 1);
        chk("up_busy_fall", busy, 0);
        tick();
        chk("up_done_pulse", done, 0);

        set_cfg(50, 5, 20, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        foreach (pin_dn[i]) begin
            tick();
            chk("dn_ftw", ftw_out, pin_dn[i]);
        end
        tick();
        chk("dn_done", done, 1);
        tick();

        set_cfg(100, 130, 10, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();

        set_cfg(7, 99, 0, 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("step0_ftw", ftw_out, 7);
        repeat (2) tick();
        chk("step0_done", done, 1);
        tick();

        set_cfg(24'hFFFFF0, 24'hFFFFFF, 24'h20, 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("ov_first", ftw_out, 24'hFFFFF0);
        repeat (2) tick();
        chk("ov_clamp", ftw_out, 24'hFFFFFF);
        repeat (2) tick();
        chk("ov_done", done, 1);
        tick();

        set_cfg(100, 130, 10, 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        set_cfg(1, 2, 1, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_ign", ftw_out, 110);
        repeat (12) tick();
`endif

        set_cfg(100, 130, 10, 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_hold", ftw_out, 110);
        repeat (15) begin
            tick();
            chk("abort_nodone", done, 0);
        end

        set_cfg(200, 230, 10, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("restart_ftw", ftw_out, 200);
        chk("restart_busy", busy, 1);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();

        set_cfg(100, 130, 10, 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ftw", ftw_out, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_upd", ftw_update, 0);
        chk("mid_rst_done", done, 0);
        tick();

`ifdef NCO_SWEEP_BIDIR_EN
        set_cfg(0, 20, 10, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        foreach (tri_seq[i]) begin
            tick();
            chk("tri_ftw", ftw_out, tri_seq[i]);
            chk("tri_nodone", done, 0);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
`endif

        for (int i = 0; i < 20000; i++) begin
            rst   = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 39) == 0);
            if (BIDIR && m_act && (m_cyc - m_t0 > 300)) abort = 1'b1;
            if ($urandom_range(0, 1) == 0) rand_cfg();
            tick();
        end

        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
